// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage.
package mem_pkg;

  localparam int DATA_W          = 16;
  localparam int REG_W           = 3;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  // EX/MEM pipeline record.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] store_data;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [REG_W-1:0]  wb_reg;
    logic              halt;
  } exmem_t;

  // MEM/WB pipeline record.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              halt;
  } memwb_t;

  function automatic logic is_mem(input exmem_t r);
    return r.mem_read | r.mem_write;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Width-parameterised pipeline register with load enable and synchronous clear.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear has priority over load; otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), and all
    // sequential state is written with <= so every register sees pre-edge values.
    if (clr)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM capture, data-memory request/done handshake with
// timeout, sticky error, and registered MEM/WB outputs.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [REG_W-1:0]  ex_wb_reg,
  input  logic              ex_halt,
  output logic              stall_out,
  output logic              dmem_en,
  output logic              dmem_wr,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_busy,
  input  logic              dmem_done,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_reg,
  output logic              wb_reg_write,
  output logic              wb_halt,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  exmem_t           ex_in, exm;
  memwb_t           wb_in, wb;
  logic             start, done_ok, timeout, retire_idle, misaligned, err_now, retire;

  assign stall_out = (state == ACCESS) | ((state == WAIT) & ~dmem_done);

  // A valid, aligned memory op entering EX/MEM this edge starts an access.
  assign start       = ~stall_out & ex_valid & (ex_mem_read | ex_mem_write) & ~ex_alu_out[0];
  assign done_ok     = (state == WAIT) & dmem_done;
  assign timeout     = (state == WAIT) & ~dmem_done & (cnt == CNT_W'(TIMEOUT - 1));
  // In IDLE, EX/MEM holds either a non-memory op or a misaligned memory op.
  assign retire_idle = (state == IDLE) & exm.valid;
  assign misaligned  = retire_idle & is_mem(exm) & exm.alu_out[0];
  assign err_now     = misaligned | timeout;
  assign retire      = retire_idle | done_ok | timeout;

  // Bubble when nothing valid is presented.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path
    // leaves it unassigned and a latch is inferred.
    ex_in = '0;
    if (ex_valid) begin
      ex_in.valid      = 1'b1;
      ex_in.alu_out    = ex_alu_out;
      ex_in.store_data = ex_store_data;
      ex_in.mem_read   = ex_mem_read;
      ex_in.mem_write  = ex_mem_write;
      ex_in.reg_write  = ex_reg_write;
      ex_in.wb_reg     = ex_wb_reg;
      ex_in.halt       = ex_halt;
    end
  end

  // EX/MEM: loads when not stalled; cleared after a timeout so the dead op
  // is not retired a second time from IDLE.
  pipe_reg #(.W($bits(exmem_t))) u_exmem (
    .clk (clk),
    .clr (rst | timeout),
    .en  (~stall_out),
    .d   (ex_in),
    .q   (exm)
  );

  // Next MEM/WB record: zero unless an instruction retires this edge.
  always_comb begin
    wb_in = '0;
    if (retire) begin
      wb_in.valid     = 1'b1;
      wb_in.data      = (done_ok & exm.mem_read) ? dmem_rdata : exm.alu_out;
      wb_in.rd        = exm.wb_reg;
      wb_in.reg_write = exm.reg_write & ~exm.mem_write & ~err_now;
      wb_in.halt      = exm.halt | err | err_now;
    end
  end

  pipe_reg #(.W($bits(memwb_t))) u_memwb (
    .clk (clk),
    .clr (rst),
    .en  (1'b1),
    .d   (wb_in),
    .q   (wb)
  );

  assign wb_valid     = wb.valid;
  assign wb_data      = wb.data;
  assign wb_reg       = wb.rd;
  assign wb_reg_write = wb.reg_write;
  assign wb_halt      = wb.halt;

  // Request outputs are driven only while a request is pending.
  assign dmem_en    = (state == ACCESS);
  assign dmem_wr    = dmem_en & exm.mem_write;
  assign dmem_addr  = dmem_en ? exm.alu_out    : '0;
  assign dmem_wdata = dmem_en ? exm.store_data : '0;

  // Next-state logic; a completing access may hand straight over to the next one.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ACCESS;
      ACCESS:  if (!dmem_busy) state_nx = WAIT;
      WAIT: begin
        if (done_ok)      state_nx = start ? ACCESS : IDLE;
        else if (timeout) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ACCESS)
        cnt <= '0;
      else if ((state == WAIT) && !dmem_done && !timeout)
        cnt <= cnt + CNT_W'(1);
      if (err_now)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_halt;
  logic [15:0] ex_alu_out, ex_store_data;
  logic [2:0]  ex_wb_reg;
  logic        stall_out, dmem_en, dmem_wr;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_busy, dmem_done;
  logic        wb_valid, wb_reg_write, wb_halt, err;
  logic [15:0] wb_data;
  logic [2:0]  wb_reg;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_wb_reg     (ex_wb_reg),
    .ex_halt       (ex_halt),
    .stall_out     (stall_out),
    .dmem_en       (dmem_en),
    .dmem_wr       (dmem_wr),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_busy     (dmem_busy),
    .dmem_done     (dmem_done),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_reg        (wb_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_halt       (wb_halt),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] alu;
    logic        rw;
    logic [2:0]  rd;
    logic        h;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  erd;
    logic        erw;
    logic        eh;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                          input logic rd, input logic wr, input logic rw,
                          input logic [2:0] wreg, input logic h);
    ex_valid      = v;
    ex_alu_out    = alu;
    ex_store_data = sd;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_reg_write  = rw;
    ex_wb_reg     = wreg;
    ex_halt       = h;
  endtask

  task automatic clear_ex();
    drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  // Memory responder for one access, starting just after the capture edge.
  // busy for nbusy request cycles, done in WAIT cycle number kdone (0 = never).
  task automatic mem_txn(input int nbusy, input int kdone, input logic [15:0] rdata,
                         input logic exp_wr, input logic [15:0] exp_addr,
                         input logic [15:0] exp_wdata,
                         output int stall_cyc, output int en_cyc, output int wait_cyc,
                         output int en_bad, output bit ended);
    bit done_given;
    stall_cyc = 0; en_cyc = 0; wait_cyc = 0; en_bad = 0; ended = 1'b0;
    for (int c = 0; c < 64; c++) begin
      dmem_busy = 1'b0; dmem_done = 1'b0; done_given = 1'b0;
      #1;
      if (dmem_en) begin
        if (dmem_wr !== exp_wr || dmem_addr !== exp_addr || dmem_wdata !== exp_wdata)
          en_bad++;
        dmem_busy = (en_cyc < nbusy);
        en_cyc++;
      end else if (en_cyc == 0 || !stall_out) begin
        ended = 1'b1;
        break;
      end else begin
        wait_cyc++;
        if (wait_cyc == kdone) begin
          dmem_done  = 1'b1;
          dmem_rdata = rdata;
          done_given = 1'b1;
        end
      end
      #1;
      if (stall_out) stall_cyc++;
      tick();
      if (done_given) begin
        ended = 1'b1;
        break;
      end
    end
    dmem_busy = 1'b0;
    dmem_done = 1'b0;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [15:0] d,
                          input logic [2:0] r, input logic rw, input logic h);
    check({tag, " wb_valid"}, wb_valid, v);
    check({tag, " wb_data"}, wb_data, d);
    check({tag, " wb_reg"}, wb_reg, r);
    check({tag, " wb_reg_write"}, wb_reg_write, rw);
    check({tag, " wb_halt"}, wb_halt, h);
  endtask

  int sc, ec, wc, eb;
  bit fin;

  initial begin
    vecs[0] = '{1'b1, 16'h1234, 1'b1, 3'd5, 1'b0, 1'b1, 16'h1234, 3'd5, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 1'b1, 3'd7, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'hABCD, 1'b0, 3'd7, 1'b0, 1'b1, 16'hABCD, 3'd7, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'h0001, 1'b1, 3'd1, 1'b0, 1'b1, 16'h0001, 3'd1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h8000, 1'b1, 3'd6, 1'b0, 1'b1, 16'h8000, 3'd6, 1'b1, 1'b0};

    rst = 1'b1; clear_ex();
    dmem_busy = 1'b0; dmem_done = 1'b0; dmem_rdata = 16'h0;
    tick(); tick();
    check("rst stall_out", stall_out, 0);
    check("rst dmem_en", dmem_en, 0);
    check("rst dmem_addr", dmem_addr, 0);
    check("rst err", err, 0);
    check_wb("rst", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Non-memory pass-through, latency 1.
    for (int i = 0; i < 6; i++) begin
      drive_ex(vecs[i].v, vecs[i].alu, 16'h0, 1'b0, 1'b0, vecs[i].rw, vecs[i].rd, vecs[i].h);
      #1;
      check($sformatf("vec%0d stall", i), stall_out, 0);
      tick();
      clear_ex();
      #1;
      check($sformatf("vec%0d stall2", i), stall_out, 0);
      tick();
      check_wb($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].erd, vecs[i].erw, vecs[i].eh);
      tick();
      check($sformatf("vec%0d pulse", i), wb_valid, 0);
    end

    // Load 0x0040, done in the third WAIT cycle.
    drive_ex(1'b1, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    tick();
    clear_ex();
    mem_txn(0, 3, 16'hBEEF, 1'b0, 16'h0040, 16'h0000, sc, ec, wc, eb, fin);
    check("load ended", fin, 1);
    check("load stall cycles", sc, 3);
    check("load en cycles", ec, 1);
    check("load req fields", eb, 0);
    check_wb("load", 1'b1, 16'hBEEF, 3'd2, 1'b1, 1'b0);
    tick();
    check("load pulse", wb_valid, 0);

    // Store with two busy cycles.
    drive_ex(1'b1, 16'h0010, 16'h00AA, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    clear_ex();
    mem_txn(2, 1, 16'hDEAD, 1'b1, 16'h0010, 16'h00AA, sc, ec, wc, eb, fin);
    check("store ended", fin, 1);
    check("store en cycles", ec, 3);
    check("store stall cycles", sc, 3);
    check("store req fields", eb, 0);
    check_wb("store", 1'b1, 16'h0010, 3'd0, 1'b0, 1'b0);

    // Load then store back-to-back: the store enters on the done edge.
    tick();
    drive_ex(1'b1, 16'h0080, 16'h0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
    tick();
    clear_ex();
    tick();
    drive_ex(1'b1, 16'h0090, 16'h00CC, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    dmem_done = 1'b1; dmem_rdata = 16'h1111;
    #1;
    check("b2b stall in done", stall_out, 0);
    tick();
    clear_ex(); dmem_done = 1'b0;
    #1;
    check_wb("b2b load", 1'b1, 16'h1111, 3'd3, 1'b1, 1'b0);
    check("b2b store en", dmem_en, 1);
    check("b2b store addr", dmem_addr, 16'h0090);
    mem_txn(0, 1, 16'h0, 1'b1, 16'h0090, 16'h00CC, sc, ec, wc, eb, fin);
    check("b2b store ended", fin, 1);
    check("b2b store fields", eb, 0);
    check_wb("b2b store", 1'b1, 16'h0090, 3'd0, 1'b0, 1'b0);

    // Misaligned load: no request, error on the next edge, sticky.
    tick();
    drive_ex(1'b1, 16'h0041, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
    tick();
    clear_ex();
    #1;
    check("mis dmem_en", dmem_en, 0);
    check("mis stall", stall_out, 0);
    check("mis err early", err, 0);
    tick();
    check("mis err", err, 1);
    check_wb("mis", 1'b1, 16'h0041, 3'd1, 1'b0, 1'b1);
    drive_ex(1'b1, 16'h0042, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    tick();
    clear_ex();
    tick();
    check_wb("post-err", 1'b1, 16'h0042, 3'd3, 1'b1, 1'b1);
    tick(); tick();
    check("err sticky", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err cleared", err, 0);

    // Timeout: done never arrives.
    drive_ex(1'b1, 16'h0100, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
    tick();
    clear_ex();
    mem_txn(0, 0, 16'h0, 1'b0, 16'h0100, 16'h0000, sc, ec, wc, eb, fin);
    check("to ended", fin, 1);
    check("to wait cycles", wc, 16);
    check("to stall cycles", sc, 17);
    check("to err", err, 1);
    check_wb("to", 1'b1, 16'h0100, 3'd4, 1'b0, 1'b1);
    tick();
    check("to no reretire", wb_valid, 0);
    check("to idle en", dmem_en, 0);
    check("to idle stall", stall_out, 0);

    // Reset in the second WAIT cycle, then a late done.
    drive_ex(1'b1, 16'h0020, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    tick();
    clear_ex();
    tick();
    tick();
    #1;
    check("rw in wait stall", stall_out, 1);
    check("rw in wait en", dmem_en, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dmem_done = 1'b1; dmem_rdata = 16'h7777;
    #1;
    check("rw dmem_en", dmem_en, 0);
    check("rw stall", stall_out, 0);
    check("rw dmem_addr", dmem_addr, 0);
    check("rw err", err, 0);
    check_wb("rw", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    tick();
    dmem_done = 1'b0;
    check("rw late done valid", wb_valid, 0);
    check("rw late done data", wb_data, 0);
    tick();
    check("rw idle valid", wb_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
